// File: rtl/sram_arbiter.sv
// SRAM arbiter: shares one 8-bit asynchronous SRAM between the 6502 and a DMA
// requester. CPU writes are posted through a small FIFO. CPU reads stall the
// CPU through RDY. DMA uses a req/ack handshake. Every SRAM access is
// sequenced as a fixed-length ACCESS phase. Every write is followed by a TURN
// cycle, so the data bus is released before anything else drives it.
module sram_arbiter #(
  parameter int AW         = 16,
  parameter int ACC_CYC    = 2,
  parameter int WBUF_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_sel,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic [7:0]    dma_rdata,
  output logic          dma_ack,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_dout,
  input  logic [7:0]    sram_din,
  output logic          sram_oe,
  output logic          sram_ce_n,
  output logic          sram_we_n,
  output logic          wbuf_ovf
);

  localparam int              PW         = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [3:0]      LAST_CNT   = 4'(ACC_CYC - 1);
  localparam logic [PW:0]     FULL_CNT   = (PW + 1)'(WBUF_DEPTH);
  localparam logic [PW:0]     ZERO_CNT   = (PW + 1)'(0);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_CPU_RD = 2'd0, SRC_CPU_WR = 2'd1, SRC_DMA = 2'd2} src_t;

  state_t          state, state_nx;
  src_t            src, grant_src;
  logic [3:0]      cnt;
  logic            op_we;
  logic            grant, grant_we;
  logic [AW-1:0]   grant_addr;
  logic [7:0]      grant_data;
  logic            rd_done;
  logic [SW-1:0]   starve;

  logic [AW-1:0]   fifo_addr [WBUF_DEPTH];
  logic [7:0]      fifo_data [WBUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     fifo_cnt;

  logic fifo_empty, fifo_full, push, pop, wr_attempt;
  logic cpu_rd_pend, dma_pend, last, acc_end;

  assign fifo_empty  = (fifo_cnt == ZERO_CNT);
  assign fifo_full   = (fifo_cnt == FULL_CNT);
  assign wr_attempt  = cpu_sel & cpu_we;
  assign push        = wr_attempt & ~fifo_full;
  assign cpu_rd_pend = cpu_sel & ~cpu_we & ~rd_done;
  // The ack cycle still shows dma_req high; that is the request just served.
  assign dma_pend    = dma_req & ~dma_ack;
  assign last        = (cnt == LAST_CNT);
  assign acc_end     = (state == ACCESS) & last;
  assign pop         = acc_end & (src == SRC_CPU_WR);
  assign cpu_rdy     = ~(cpu_sel & ~cpu_we & ~rd_done);

  // Arbitration in IDLE and next-state selection.
  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_src  = SRC_CPU_RD;
    grant_we   = 1'b0;
    grant_addr = {AW{1'b0}};
    grant_data = 8'h00;
    case (state)
      IDLE: begin
        if (dma_pend && (starve == STARVE_LIM)) begin
          grant = 1'b1; grant_src = SRC_DMA; grant_we = dma_we;
          grant_addr = dma_addr; grant_data = dma_wdata;
        end else if (!fifo_empty) begin
          grant = 1'b1; grant_src = SRC_CPU_WR; grant_we = 1'b1;
          grant_addr = fifo_addr[rd_ptr]; grant_data = fifo_data[rd_ptr];
        end else if (cpu_rd_pend) begin
          grant = 1'b1; grant_src = SRC_CPU_RD; grant_we = 1'b0;
          grant_addr = cpu_addr;
        end else if (dma_pend) begin
          grant = 1'b1; grant_src = SRC_DMA; grant_we = dma_we;
          grant_addr = dma_addr; grant_data = dma_wdata;
        end else begin
          grant = 1'b0;
        end
        if (grant) begin
          state_nx = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (last) begin
          state_nx = op_we ? TURN : IDLE;
        end else begin
          state_nx = ACCESS;
        end
      end
      TURN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, access cycle counter and latched operation type.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      src   <= SRC_CPU_RD;
      op_we <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        cnt   <= 4'd0;
        src   <= grant_src;
        op_we <= grant_we;
      end else if ((state == ACCESS) && !last) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Registered SRAM strobes; address and data are held from grant through TURN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe   <= 1'b0;
      sram_addr <= {AW{1'b0}};
      sram_dout <= 8'h00;
    end else if (grant) begin
      sram_ce_n <= 1'b0;
      sram_we_n <= 1'b1;
      sram_oe   <= grant_we;
      sram_addr <= grant_addr;
      sram_dout <= grant_data;
    end else if ((state == ACCESS) && !last) begin
      sram_ce_n <= 1'b0;
      sram_we_n <= ~op_we;
      sram_oe   <= op_we;
    end else begin
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe   <= 1'b0;
    end
  end

  // Read data capture and the one-cycle completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_done   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
    end else begin
      rd_done <= acc_end & (src == SRC_CPU_RD);
      dma_ack <= acc_end & (src == SRC_DMA);
      if (acc_end && (src == SRC_CPU_RD)) cpu_rdata <= sram_din;
      if (acc_end && (src == SRC_DMA) && !op_we) dma_rdata <= sram_din;
    end
  end

  // Count CPU grants made while DMA waits, so DMA cannot starve.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= {SW{1'b0}};
    end else if (!dma_req || (grant && (grant_src == SRC_DMA))) begin
      starve <= {SW{1'b0}};
    end else if (grant && (starve != STARVE_LIM)) begin
      starve <= starve + SW'(1);
    end
  end

  // Posted-write FIFO storage (data path only, no reset needed).
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      fifo_cnt <= ZERO_CNT;
      wbuf_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (PW + 1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (PW + 1)'(1);
      if (wr_attempt && fifo_full) wbuf_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter. A 64-byte mirrored SRAM sits on the bus. A
// transaction-level reference model predicts every DUT output each cycle. The
// model keeps a queue of posted writes, a shadow memory and the number of
// cycles since the current grant. Directed scenarios run first, then
// randomized CPU/DMA traffic.
module tb_sram_arbiter;
  localparam int AW = 16, ACC = 2, DEPTH = 4, SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_sel, cpu_we, cpu_rdy;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [7:0]    dma_wdata, dma_rdata;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dout, sram_din;
  logic          sram_oe, sram_ce_n, sram_we_n, wbuf_ovf;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(AW), .ACC_CYC(ACC), .WBUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel(cpu_sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_oe(sram_oe), .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .wbuf_ovf(wbuf_ovf)
  );

  // Bench SRAM: 64 bytes mirrored across the address space, cleared on reset.
  logic [7:0] mem [64];
  assign sram_din = mem[sram_addr[5:0]];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (!sram_ce_n && !sram_we_n && sram_oe) begin
      mem[sram_addr[5:0]] <= sram_dout;
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [64];
  logic [15:0] q_addr [$];
  logic [7:0]  q_data [$];
  bit          m_busy, m_we, m_ovf, m_rd_done, m_ack;
  int          m_t, m_len, m_kind, m_starve;   // kind: 0 CPU read, 1 CPU write, 2 DMA
  logic [15:0] m_addr;
  logic [7:0]  m_data, m_cpu_rdata, m_dma_rdata;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    q_addr.delete(); q_data.delete();
    m_busy = 0; m_we = 0; m_ovf = 0; m_rd_done = 0; m_ack = 0;
    m_t = 0; m_len = 0; m_kind = 0; m_starve = 0;
    m_addr = 16'h0000; m_data = 8'h00; m_cpu_rdata = 8'h00; m_dma_rdata = 8'h00;
  endtask

  task automatic model_start(input int kind, input bit we, input logic [15:0] a, input logic [7:0] d);
    m_busy = 1; m_t = 0; m_kind = kind; m_we = we; m_addr = a; m_data = d;
    m_len = ACC + (we ? 1 : 0);
  endtask

  // Called once per cycle at the falling edge: check outputs, then advance.
  task automatic model_step();
    bit in_acc, full, cg, dg, n_rd, n_ack, dma_want;
    in_acc = m_busy && (m_t < ACC);
    check_eq("sram_ce_n", sram_ce_n, !in_acc);
    check_eq("sram_we_n", sram_we_n, !(in_acc && m_we && (m_t >= 1)));
    check_eq("sram_oe", sram_oe, in_acc && m_we);
    if (in_acc) begin
      check_eq("sram_addr", sram_addr, m_addr);
      if (m_we) check_eq("sram_dout", sram_dout, m_data);
    end
    check_eq("cpu_rdy", cpu_rdy, !(cpu_sel && !cpu_we && !m_rd_done));
    check_eq("dma_ack", dma_ack, m_ack);
    check_eq("cpu_rdata", cpu_rdata, m_cpu_rdata);
    check_eq("dma_rdata", dma_rdata, m_dma_rdata);
    check_eq("wbuf_ovf", wbuf_ovf, m_ovf);

    full = (q_addr.size() == DEPTH);
    cg = 0; dg = 0; n_rd = 0; n_ack = 0;
    if (m_busy) begin
      if (m_t == ACC - 1) begin
        case (m_kind)
          0: begin m_cpu_rdata = ref_mem[m_addr[5:0]]; n_rd = 1; end
          1: begin
            ref_mem[m_addr[5:0]] = m_data;
            void'(q_addr.pop_front()); void'(q_data.pop_front());
          end
          default: begin
            if (m_we) ref_mem[m_addr[5:0]] = m_data;
            else m_dma_rdata = ref_mem[m_addr[5:0]];
            n_ack = 1;
          end
        endcase
      end
      m_t++;
      if (m_t == m_len) m_busy = 0;
    end else begin
      dma_want = dma_req && !m_ack;
      if (dma_want && (m_starve == SMAX)) dg = 1;
      else if (q_addr.size() > 0) begin cg = 1; model_start(1, 1, q_addr[0], q_data[0]); end
      else if (cpu_sel && !cpu_we && !m_rd_done) begin cg = 1; model_start(0, 0, cpu_addr, 8'h00); end
      else if (dma_want) dg = 1;
      if (dg) model_start(2, dma_we, dma_addr, dma_wdata);
    end
    if (!dma_req || dg) m_starve = 0;
    else if (cg && (m_starve < SMAX)) m_starve++;
    if (cpu_sel && cpu_we) begin
      if (full) m_ovf = 1;
      else begin q_addr.push_back(cpu_addr); q_data.push_back(cpu_wdata); end
    end
    m_rd_done = n_rd; m_ack = n_ack;
  endtask

  // One clock: drive inputs just after the rising edge, check at the falling edge.
  task automatic run_cycle(input logic sel, input logic we, input logic [15:0] a, input logic [7:0] d,
                           input logic dq, input logic dw, input logic [15:0] da, input logic [7:0] dd);
    @(posedge clk); #1;
    cpu_sel = sel; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    dma_req = dq; dma_we = dw; dma_addr = da; dma_wdata = dd;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic compare_mem(input string tag);
    for (int i = 0; i < 64; i++) check_eq(tag, mem[i], ref_mem[i]);
  endtask

  initial begin
    int stall, guard, nw;
    logic sel, we, dq, dw;
    logic [15:0] a, da;
    logic [7:0] d, dd;

    reset = 1'b1;
    cpu_sel = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(2);
    check_eq("reset_rdy", cpu_rdy, 1'b1);
    check_eq("reset_ce_n", sram_ce_n, 1'b1);

    // Preload 0x3123=A5 with a DMA write, then CPU read: 1+ACC stall cycles.
    guard = 0;
    do begin
      run_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h3123, 8'hA5);
      guard++;
    end while (!dma_ack && guard < 20);
    check_eq("t1_dma_ack_seen", dma_ack, 1'b1);
    idle_cycles(3);
    run_cycle(1'b1, 1'b0, 16'h3123, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    stall = 0;
    while (!cpu_rdy && stall < 30) begin
      stall++;
      run_cycle(1'b1, 1'b0, 16'h3123, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    check_eq("t1_stall", stall, ACC + 1);
    check_eq("t1_rdata", cpu_rdata, 8'hA5);
    idle_cycles(2);

    // Three back-to-back posted writes never stall the CPU.
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b1, 16'(16'h3000 + i), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 16'h0000, 8'h00);
      check_eq("t2_rdy", cpu_rdy, 1'b1);
    end
    idle_cycles(15);

    // Read right after a write waits for the drain and returns the new byte.
    run_cycle(1'b1, 1'b1, 16'h3040, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00);
    run_cycle(1'b1, 1'b0, 16'h3040, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    stall = 1;
    while (!cpu_rdy && stall < 30) begin
      stall++;
      run_cycle(1'b1, 1'b0, 16'h3040, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    check_eq("t3_stall", stall, 2 * ACC + 4);
    check_eq("t3_rdata", cpu_rdata, 8'h5A);
    idle_cycles(3);

    // DMA waits behind a steady stream of queued CPU writes for SMAX grants.
    for (int i = 0; i < 4; i++)
      run_cycle(1'b1, 1'b1, 16'(16'h3050 + i), 8'(8'h60 + i), 1'b0, 1'b0, 16'h0000, 8'h00);
    nw = 0; guard = 0;
    do begin
      run_cycle(1'b1, 1'b1, 16'h3058, 8'h99, 1'b1, 1'b0, 16'h3123, 8'h00);
      if (!sram_we_n) nw++;
      guard++;
    end while (!dma_ack && guard < 80);
    check_eq("t4_cpu_grants", nw, SMAX);
    check_eq("t4_dma_rdata", dma_rdata, 8'hA5);
    check_eq("t4_ovf", wbuf_ovf, 1'b1);
    idle_cycles(1);
    check_eq("t4_ack_pulse", dma_ack, 1'b0);
    idle_cycles(25);
    compare_mem("mem_directed");

    // Randomized traffic; the CPU holds a stalled read, DMA holds until ack.
    for (int k = 0; k < 3000; k++) begin
      sel = cpu_sel; we = cpu_we; a = cpu_addr; d = cpu_wdata;
      if (!(cpu_sel && !cpu_we && !cpu_rdy)) begin
        int r;
        r = $urandom_range(0, 99);
        a = 16'(16'h3000 + $urandom_range(0, 63));
        d = 8'($urandom);
        if (k < 1000)      begin sel = (r < 50); we = (r < 25); end
        else if (k < 2000) begin sel = (r < 70); we = (r < 60); end
        else               begin sel = (r < 80); we = (r < 10); end
      end
      dq = dma_req; dw = dma_we; da = dma_addr; dd = dma_wdata;
      if (dma_req && dma_ack) dq = 1'b0;
      else if (!dma_req && ($urandom_range(0, 99) < 20)) begin
        dq = 1'b1; dw = 1'($urandom); da = 16'(16'h3000 + $urandom_range(0, 63)); dd = 8'($urandom);
      end
      run_cycle(sel, we, a, d, dq, dw, da, dd);
    end
    idle_cycles(25);
    compare_mem("mem_random");

    // Reset during the write strobe: strobes drop at once, queue is lost.
    run_cycle(1'b1, 1'b1, 16'h3011, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00);
    guard = 0;
    while (sram_we_n && guard < 10) begin
      idle_cycles(1);
      guard++;
    end
    check_eq("t6_we_seen", sram_we_n, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_eq("t6_we_n_async", sram_we_n, 1'b1);
    check_eq("t6_ce_n_async", sram_ce_n, 1'b1);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(6);
    check_eq("t6_ovf_clear", wbuf_ovf, 1'b0);
    compare_mem("mem_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
